// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide constants.
//   REG_N_DEFAULT   : number of architectural registers (r0 hard-wired zero)
//   MAX_LAT_DEFAULT : longest forwarding latency the scoreboard tracks
//   LAT_*           : issue_lat values the decoder drives per instruction class
package cpu_pkg;

  localparam int unsigned REG_N_DEFAULT   = 32;
  localparam int unsigned MAX_LAT_DEFAULT = 4;

  // Cycles after issue before a result can be forwarded.
  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_MUL  = 3;
  localparam int unsigned LAT_DIV  = MAX_LAT_DEFAULT;

endpackage

// File: rtl/id_scoreboard_sb_counter.sv
// sb_counter: one register's forwarding countdown.
//   clk, rst  : clock, synchronous active-high reset
//   load      : a new producer for this register issues this cycle
//   load_val  : its forwarding latency (wins over the decrement)
//   count     : current countdown value
//   busy      : count != 0
//   busy_next : value busy will take after the next edge (ignores rst)
module sb_counter
  import cpu_pkg::*;
#(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] count,
  output logic             busy,
  output logic             busy_next
);

  logic [LAT_W-1:0] count_next;

  // Decrement runs every cycle, stalled or not, and stops at zero.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (count != '0) begin
      count_next = count - LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign busy      = (count != '0);
  assign busy_next = (count_next != '0);

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage register hazard scoreboard for results of
// latency 0..MAX_LAT cycles.
//   clk, rst            : clock, synchronous active-high reset
//   rs_read/rs_addr     : decoding instruction's rs operand
//   rt_read/rt_addr     : decoding instruction's rt operand
//   issue_valid         : decoding instruction wants to enter EX
//   issue_wreg/issue_wd : it writes register issue_wd
//   issue_lat           : cycles until its result is forwardable (0 = ALU)
//   stall_o             : decode stall request (RAW on rs/rt, or WAW)
//   issue_fire_o        : issue_valid && !stall_o
//   busy_o              : per-register "result still in flight"
//   pending_o           : number of busy registers
module id_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned REG_N   = REG_N_DEFAULT,
  parameter int unsigned MAX_LAT = MAX_LAT_DEFAULT,
  parameter int unsigned ADDR_W  = $clog2(REG_N),
  parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs_read,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              rt_read,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              issue_valid,
  input  logic              issue_wreg,
  input  logic [ADDR_W-1:0] issue_wd,
  input  logic [LAT_W-1:0]  issue_lat,
  output logic              stall_o,
  output logic              issue_fire_o,
  output logic [REG_N-1:0]  busy_o,
  output logic [ADDR_W:0]   pending_o
);

  localparam int unsigned PEND_W = ADDR_W + 1;

  logic [REG_N-1:0][LAT_W-1:0] count;
  logic [REG_N-1:0]            busy;
  logic [REG_N-1:0]            busy_next;
  logic [PEND_W-1:0]           pending_q;
  logic [PEND_W-1:0]           pending_next;
  logic                        raw_rs;
  logic                        raw_rt;
  logic                        waw;
  logic                        issue_write;

  // r0 never holds a pending result, so reads of it never stall.
  assign count[0]     = '0;
  assign busy[0]      = 1'b0;
  assign busy_next[0] = 1'b0;

  // Operands are compared against pre-issue state, so an instruction that
  // reads and writes the same register does not stall on itself.
  assign raw_rs = rs_read && (count[rs_addr] != '0);
  assign raw_rt = rt_read && (count[rt_addr] != '0);

  // A faster write must not overtake an older, slower one to the same reg.
  assign waw = issue_valid && issue_wreg && (issue_wd != '0)
            && (issue_lat < count[issue_wd]);

  assign stall_o      = raw_rs || raw_rt || waw;
  assign issue_fire_o = issue_valid && !stall_o;
  assign issue_write  = issue_fire_o && issue_wreg;

  for (genvar r = 1; r < REG_N; r++) begin : g_cnt
    sb_counter #(
      .LAT_W(LAT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (issue_write && (issue_wd == ADDR_W'(r))),
      .load_val (issue_lat),
      .count    (count[r]),
      .busy     (busy[r]),
      .busy_next(busy_next[r])
    );
  end

  // pending is registered from the counters' next-state busy bits so that
  // it always matches popcount(busy_o) in the same cycle.
  always_comb begin
    pending_next = '0;
    for (int unsigned r = 0; r < REG_N; r++) begin
      pending_next = pending_next + PEND_W'(busy_next[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

  assign busy_o    = busy;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: table-driven directed bench for id_scoreboard, plus
// hand-written sequences for mid-operation reset and stall-release timing.
module tb_id_scoreboard;
  import cpu_pkg::*;

  localparam int unsigned REG_N   = 32;
  localparam int unsigned MAX_LAT = 4;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned LAT_W   = 3;

  logic              clk;
  logic              rst;
  logic              rs_read;
  logic [ADDR_W-1:0] rs_addr;
  logic              rt_read;
  logic [ADDR_W-1:0] rt_addr;
  logic              issue_valid;
  logic              issue_wreg;
  logic [ADDR_W-1:0] issue_wd;
  logic [LAT_W-1:0]  issue_lat;
  logic              stall_o;
  logic              issue_fire_o;
  logic [REG_N-1:0]  busy_o;
  logic [ADDR_W:0]   pending_o;

  id_scoreboard #(
    .REG_N  (REG_N),
    .MAX_LAT(MAX_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs_read     (rs_read),
    .rs_addr     (rs_addr),
    .rt_read     (rt_read),
    .rt_addr     (rt_addr),
    .issue_valid (issue_valid),
    .issue_wreg  (issue_wreg),
    .issue_wd    (issue_wd),
    .issue_lat   (issue_lat),
    .stall_o     (stall_o),
    .issue_fire_o(issue_fire_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && issue_valid) begin
      assert (issue_lat <= LAT_W'(MAX_LAT))
        else $error("illegal issue_lat %0d", issue_lat);
    end
  end

  typedef struct {
    logic        rst;
    logic        rs_read;
    logic [4:0]  rs_addr;
    logic        rt_read;
    logic [4:0]  rt_addr;
    logic        iv;
    logic        iw;
    logic [4:0]  wd;
    logic [2:0]  lat;
    logic        chk;
    logic        e_stall;
    logic        e_fire;
    logic [31:0] e_busy;
    logic [5:0]  e_pend;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic r, input logic rsr, input int rsa,
                              input logic rtr, input int rta,
                              input logic iv, input logic iw, input int wd,
                              input int lat, input logic chk, input logic es,
                              input logic ef, input logic [31:0] eb,
                              input int ep);
    vec_t v;
    v.rst = r;        v.rs_read = rsr; v.rs_addr = 5'(rsa);
    v.rt_read = rtr;  v.rt_addr = 5'(rta);
    v.iv = iv;        v.iw = iw;       v.wd = 5'(wd);  v.lat = 3'(lat);
    v.chk = chk;      v.e_stall = es;  v.e_fire = ef;
    v.e_busy = eb;    v.e_pend = 6'(ep);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst         = v.rst;
    rs_read     = v.rs_read;
    rs_addr     = v.rs_addr;
    rt_read     = v.rt_read;
    rt_addr     = v.rt_addr;
    issue_valid = v.iv;
    issue_wreg  = v.iw;
    issue_wd    = v.wd;
    issue_lat   = v.lat;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int stalls;
    bit fired;

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));

    // rst, rs_read, rs, rt_read, rt, iv, iw, wd, lat, chk, stall, fire, busy, pend
    // Reset held two cycles with an issue pending: nothing may load.
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 3, 0, 0, 0, 32'h0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 3, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
    // Load-use: one stall cycle.
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8, 1, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 1, 8, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h100, 1));
    tv.push_back(mk(0, 1, 8, 0, 0, 1, 0, 0, 0, 1, 0, 1, 32'h0, 0));
    // Multi-cycle lat=3 on rt: three stall cycles.
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 3, 3, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0, 0, 1, 1, 0, 32'h8, 1));
    tv.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0, 0, 1, 1, 0, 32'h8, 1));
    tv.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0, 0, 1, 1, 0, 32'h8, 1));
    tv.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0, 0, 1, 0, 1, 32'h0, 0));
    // WAW: lat=0 write waits until count[4] drains, then leaves r4 idle.
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, 3, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, 0, 1, 1, 0, 32'h10, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, 0, 1, 1, 0, 32'h10, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, 0, 1, 1, 0, 32'h10, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, 0, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
    // Register 0: write ignored, read never stalls.
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 4, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 32'h0, 0));
    // Overlap r1 lat=4, r2 lat=2: pending 1,2,2,1,0.
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 4, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 2, 1, 0, 1, 32'h2, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h6, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h6, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h2, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
    // Reissue to r6 while count=1: new latency wins over the decrement.
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 6, 1, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 6, 3, 1, 0, 1, 32'h40, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
    // Self-read of r7 uses pre-issue state; the next reader stalls.
    tv.push_back(mk(0, 1, 7, 0, 0, 1, 1, 7, 2, 1, 0, 1, 32'h0, 0));
    tv.push_back(mk(0, 1, 7, 1, 9, 1, 0, 0, 0, 1, 1, 0, 32'h80, 1));
    tv.push_back(mk(0, 1, 7, 1, 9, 1, 0, 0, 0, 1, 1, 0, 32'h80, 1));
    tv.push_back(mk(0, 1, 7, 1, 9, 1, 0, 0, 0, 1, 0, 1, 32'h0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      if (tv[i].chk) begin
        check($sformatf("v%0d stall", i), 32'(stall_o), 32'(tv[i].e_stall));
        check($sformatf("v%0d fire", i), 32'(issue_fire_o), 32'(tv[i].e_fire));
        check($sformatf("v%0d busy", i), busy_o, tv[i].e_busy);
        check($sformatf("v%0d pend", i), 32'(pending_o), 32'(tv[i].e_pend));
      end
    end

    // Reset in the middle of a pending lat=4 result on r10.
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 1, 1, 10, 4, 0, 0, 0, 32'h0, 0));
    #2;
    check("midrst issue fire", 32'(issue_fire_o), 32'h1);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    #2;
    check("midrst busy before", busy_o, 32'h400);
    check("midrst pend before", 32'(pending_o), 32'h1);
    @(negedge clk);
    drive(mk(0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    #2;
    check("midrst busy after", busy_o, 32'h0);
    check("midrst pend after", 32'(pending_o), 32'h0);
    check("midrst stall after", 32'(stall_o), 32'h0);

    // lat=4 producer on r12 followed directly by a consumer: four stalls.
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 1, 1, 12, 4, 0, 0, 0, 32'h0, 0));
    stalls = 0;
    fired  = 1'b0;
    for (int c = 0; c < 10 && !fired; c++) begin
      @(negedge clk);
      if (c == 0) drive(mk(0, 1, 12, 1, 12, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
      #2;
      if (issue_fire_o) fired = 1'b1;
      else stalls++;
    end
    check("release seen", 32'(fired), 32'h1);
    check("release stall cycles", 32'(stalls), 32'd4);
    check("release pend", 32'(pending_o), 32'h0);

    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
